sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port byte-masked SRAM macro (DW=32, active-low csb/wenb, 4-bit wmask, 1-cycle read latency). It shares one SRAM instance between an instruction-fetch port (port 0, read-only) and a data port (port 1, read/write) using round-robin arbitration. It drives the SRAM command pins and routes the returned read data back to the granted requester with a response-valid pulse. It sits between the core's memory interfaces and the SRAM wrapper in the memory subsystem.

Parameters:
DW, 32, data width; fixed at 32 because the SRAM byte mask is 4 bits.
AW, 8, SRAM word-address width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
p0_req  input  1  port 0 read request.
p0_addr  input  AW  port 0 word address.
p0_gnt  output  1  port 0 request accepted this cycle.
p0_rvalid  output  1  port 0 read data valid.
p0_rdata  output  DW  port 0 read data.
p1_req  input  1  port 1 request.
p1_we  input  1  port 1 write enable; 1 = write, 0 = read.
p1_be  input  4  port 1 byte enables, used for writes only.
p1_addr  input  AW  port 1 word address.
p1_wdata  input  DW  port 1 write data.
p1_gnt  output  1  port 1 request accepted this cycle.
p1_rvalid  output  1  port 1 response valid; pulses for both reads and writes.
p1_rdata  output  DW  port 1 read data; 0 on write responses.
sram_csb  output  1  SRAM chip select, active-low.
sram_wenb  output  1  SRAM write enable, active-low.
sram_wmask  output  4  SRAM byte mask.
sram_addr  output  AW  SRAM address.
sram_wdata  output  DW  SRAM write data.
sram_rdata  input  DW  SRAM read data, valid the cycle after a read command.

Behaviour:
- Grant logic is combinational from req and registered state. The SRAM command is driven in the same cycle as gnt, so the SRAM samples it on the next rising edge.
- Only one requester gets gnt per cycle (one-hot or none). If req is high and gnt is low, the requester holds req and its address/data stable.
- Round-robin pointer prio (1 bit) selects the favoured port:
  - Both ports requesting: the port equal to prio wins.
  - One port requesting: that port wins regardless of prio.
  - After any grant to port k, prio becomes !k.
  - Reset value of prio: 0.
- Command mux:
  - No grant: sram_csb=1, sram_wenb=1, sram_wmask=0, sram_addr=0, sram_wdata=0.
  - Port 0 grant: csb=0, wenb=1, wmask=0, addr=p0_addr.
  - Port 1 grant: csb=0, wenb=!p1_we, wmask = p1_we ? p1_be : 0, addr=p1_addr, wdata=p1_wdata.
- Response tracking: registered rsp_vld, rsp_port, rsp_wr capture the grant. In the next cycle the owning port's rvalid=1 for exactly one cycle.
  - Read response: rdata = sram_rdata.
  - Write response: rdata = 0.
  - Non-owning port: rdata = 0.
- Latency: gnt in cycle N, rvalid in cycle N+1. Back-to-back grants give one response per cycle with no bubbles.
- Write with p1_be=0: still granted, SRAM is selected but nothing is written, and a response is returned.
- Reset, asynchronous at any time: prio=0, rsp_vld=0, so all rvalid=0 and all rdata=0. A response pending at reset assertion is dropped and never delivered. Combinational gnt may still assert during reset; it is not a committed transaction.
- No FIFO; at most one transaction is in flight.

Optional Feature:
Macro SRAM_ARB_PERF_CNT_EN.
- Defined: adds outputs p0_gnt_cnt[31:0], p1_gnt_cnt[31:0] and conflict_cnt[31:0].
  - Each grant counter increments once per grant to its port.
  - conflict_cnt increments in each cycle where both req are high.
  - All counters wrap at 2^32 and reset to 0.
- Undefined: these ports and registers are absent, with no other behavioural change.

Decomposition:
- Shared package sram_arb_pkg: typedef port_id_e (PORT_IFU=0, PORT_LSU=1); constant BE_W=4; typedef sram_cmd_t struct {csb, wenb, wmask, addr, wdata}.
- One natural sub-module: rr_arb2, the 2-way round-robin arbiter (req[1:0] in, gnt[1:0] one-hot out, internal prio register). The muxing and response tracking stay in the top level.

Test Plan:
- Port 0 alone: p0_req with addr 0x10, after preloading mem[0x10]=0xDEADBEEF -> p0_gnt same cycle, sram_csb=0, sram_wenb=1; next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF.
- Port 1 byte write: be=4'b0010, wdata=0x0000AB00 to addr 0x20 holding 0x11223344, then read addr 0x20 -> read returns 0x1122AB44; the write response has p1_rdata=0.
- Both ports requesting continuously for 6 cycles after reset -> grants alternate P0,P1,P0,P1,P0,P1; the rvalids follow one cycle later with the same alternation.
- Port 1 requesting alone for 3 cycles, then both -> after three P1 grants prio=0, so P0 wins the first contended cycle.
- rst asserted in the cycle after a port 1 read grant -> p1_rvalid never pulses; after release, the first contended grant goes to P0.
- With SRAM_ARB_PERF_CNT_EN: 5 contended cycles -> conflict_cnt=5, p0_gnt_cnt=3, p1_gnt_cnt=2.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and widths for the two-port SRAM arbiter
package sram_arb_pkg;
  localparam int SRAM_DW = 32;
  localparam int SRAM_AW = 8;
  localparam int BE_W = 4;
  typedef enum logic {PORT_IFU = 1'b0, PORT_LSU = 1'b1} port_id_e;
  typedef struct packed {
    logic               csb;
    logic               wenb;
    logic [BE_W-1:0]    wmask;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
  } sram_cmd_t;
  localparam sram_cmd_t CMD_IDLE = '{csb: 1'b1, wenb: 1'b1, default: '0};
endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; prio names the favoured port
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic prio;
  always_comb begin
    gnt[0] = req[0] && (!req[1] || !prio);
    gnt[1] = req[1] && (!req[0] || prio);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) prio <= 1'b0;
    else if (|gnt) prio <= gnt[0];
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin share of one SRAM between fetch (port 0) and data (port 1)
// Optional SRAM_ARB_PERF_CNT_EN adds grant and conflict counters.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DW = SRAM_DW,
  parameter int AW = SRAM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [3:0]    p1_be,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          sram_csb,
  output logic          sram_wenb,
  output logic [3:0]    sram_wmask,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
`ifdef SRAM_ARB_PERF_CNT_EN
  output logic [31:0]   p0_gnt_cnt,
  output logic [31:0]   p1_gnt_cnt,
  output logic [31:0]   conflict_cnt,
`endif
  input  logic [DW-1:0] sram_rdata
);
  logic [1:0] gnt;
  sram_cmd_t cmd;
  logic rsp_vld, rsp_wr;
  port_id_e rsp_port;
  rr_arb2 u_arb (.clk(clk), .rst(rst), .req({p1_req, p0_req}), .gnt(gnt));
  assign p0_gnt = gnt[PORT_IFU];
  assign p1_gnt = gnt[PORT_LSU];
  always_comb begin
    cmd = CMD_IDLE;
    if (gnt[PORT_IFU]) begin
      cmd.csb = 1'b0;
      cmd.addr = p0_addr;
    end else if (gnt[PORT_LSU]) begin
      cmd.csb = 1'b0;
      cmd.wenb = !p1_we;
      cmd.wmask = p1_we ? p1_be : '0;
      cmd.addr = p1_addr;
      cmd.wdata = p1_wdata;
    end
  end
  assign sram_csb = cmd.csb;
  assign sram_wenb = cmd.wenb;
  assign sram_wmask = cmd.wmask;
  assign sram_addr = cmd.addr;
  assign sram_wdata = cmd.wdata;
  // One transaction in flight: the response belongs to last cycle's grant
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp_vld <= 1'b0;
      rsp_port <= PORT_IFU;
      rsp_wr <= 1'b0;
    end else begin
      rsp_vld <= |gnt;
      rsp_port <= gnt[PORT_LSU] ? PORT_LSU : PORT_IFU;
      rsp_wr <= gnt[PORT_LSU] && p1_we;
    end
  assign p0_rvalid = rsp_vld && rsp_port == PORT_IFU;
  assign p1_rvalid = rsp_vld && rsp_port == PORT_LSU;
  assign p0_rdata = p0_rvalid ? sram_rdata : '0;
  assign p1_rdata = (p1_rvalid && !rsp_wr) ? sram_rdata : '0;
`ifdef SRAM_ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p0_gnt_cnt <= '0;
      p1_gnt_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      p0_gnt_cnt <= p0_gnt_cnt + 32'(gnt[PORT_IFU]);
      p1_gnt_cnt <= p1_gnt_cnt + 32'(gnt[PORT_LSU]);
      conflict_cnt <= conflict_cnt + 32'(p0_req && p1_req);
    end
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench with SRAM model and response scoreboard
module tb_sram_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic p0_req = 0, p1_req = 0, p1_we = 0;
  logic [7:0] p0_addr = 0, p1_addr = 0;
  logic [3:0] p1_be = 0;
  logic [31:0] p1_wdata = 0;
  logic p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, sram_csb, sram_wenb;
  logic [31:0] p0_rdata, p1_rdata, sram_wdata, sram_rdata = 0;
  logic [3:0] sram_wmask;
  logic [7:0] sram_addr;
`ifdef SRAM_ARB_PERF_CNT_EN
  logic [31:0] p0_gnt_cnt, p1_gnt_cnt, conflict_cnt;
`endif
  typedef struct {logic port; logic [31:0] data;} rsp_t;
  rsp_t q[$];
  logic [31:0] mem[256], ref_mem[256];
  logic m_prio = 1'b0;
  int n_tests = 0, n_fail = 0;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .sram_csb(sram_csb), .sram_wenb(sram_wenb), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
`ifdef SRAM_ARB_PERF_CNT_EN
    .p0_gnt_cnt(p0_gnt_cnt), .p1_gnt_cnt(p1_gnt_cnt), .conflict_cnt(conflict_cnt),
`endif
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bm(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b+:8] = {8{be[b]}};
    return m;
  endfunction

  // SRAM macro model: one-cycle read latency, byte-masked writes
  always @(posedge clk)
    if (!sram_csb) begin
      if (sram_wenb) sram_rdata <= mem[sram_addr];
      else mem[sram_addr] <= (mem[sram_addr] & ~bm(sram_wmask)) | (sram_wdata & bm(sram_wmask));
    end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r0, input logic [7:0] a0, input logic r1, input logic we,
                     input logic [3:0] be, input logic [7:0] a1, input logic [31:0] wd);
    logic eg0, eg1;
    rsp_t e;
    @(posedge clk);
    #1;
    p0_req = r0; p0_addr = a0; p1_req = r1; p1_we = we; p1_be = be; p1_addr = a1; p1_wdata = wd;
    #4;
    if (q.size() != 0) begin
      e = q.pop_front();
      check("rvalid", {62'd0, p0_rvalid, p1_rvalid}, e.port ? 64'd1 : 64'd2);
      check("p0_rdata", {32'd0, p0_rdata}, e.port ? 64'd0 : {32'd0, e.data});
      check("p1_rdata", {32'd0, p1_rdata}, e.port ? {32'd0, e.data} : 64'd0);
    end else begin
      check("rvalid_idle", {62'd0, p0_rvalid, p1_rvalid}, 64'd0);
      check("rdata_idle", {p0_rdata, p1_rdata}, 64'd0);
    end
    eg0 = r0 && (!r1 || !m_prio);
    eg1 = r1 && (!r0 || m_prio);
    check("gnt", {62'd0, p0_gnt, p1_gnt}, {62'd0, eg0, eg1});
    check("cmd", {50'd0, sram_csb, sram_wenb, sram_wmask, sram_addr},
          {50'd0, eg0 ? {2'b01, 4'h0, a0} : eg1 ? {1'b0, !we, we ? be : 4'h0, a1} : {2'b11, 4'h0, 8'h0}});
    if (!eg0) check("wdata", {32'd0, sram_wdata}, {32'd0, eg1 ? wd : 32'd0});
    if (!rst) begin
      if (eg0) q.push_back('{1'b0, ref_mem[a0]});
      if (eg1) begin
        q.push_back('{1'b1, we ? 32'd0 : ref_mem[a1]});
        if (we) ref_mem[a1] = (ref_mem[a1] & ~bm(be)) | (wd & bm(be));
      end
      if (eg0 || eg1) m_prio = eg0;
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset between edges, drop the pending response, hold one cycle
  task automatic pulse_rst();
    rst = 1'b1;
    q.delete();
    m_prio = 1'b0;
    idle();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = {4{8'(i)}} ^ 32'h5A5A_0000;
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'h11223344; ref_mem[8'h20] = 32'h11223344;
    idle();
    rst = 1'b0;
    cyc(1, 8'h10, 0, 0, 0, 0, 0);
    idle();
    cyc(0, 0, 1, 1, 4'b0010, 8'h20, 32'h0000AB00);
    cyc(0, 0, 1, 0, 4'hF, 8'h20, 32'h0);
    idle();
    check("byte_write_mem", {32'd0, mem[8'h20]}, 64'h1122AB44);
    cyc(0, 0, 1, 1, 4'b0000, 8'h30, 32'hFFFF_FFFF);
    cyc(0, 0, 1, 0, 4'h0, 8'h30, 32'h0);
    idle();
    pulse_rst();
    for (int i = 0; i < 6; i++) cyc(1, 8'(i), 1, i[1], 4'hF, 8'(8'h40 + i), 32'hC0DE_0000 + i);
    idle();
    cyc(0, 0, 1, 0, 0, 8'h11, 0);
    cyc(0, 0, 1, 1, 4'h3, 8'h12, 32'h0BAD_F00D);
    cyc(0, 0, 1, 0, 0, 8'h12, 0);
    cyc(1, 8'h13, 1, 0, 0, 8'h14, 0);
    cyc(1, 8'h13, 1, 0, 0, 8'h14, 0);
    idle();
    cyc(0, 0, 1, 0, 0, 8'h20, 0);
    pulse_rst();
    cyc(1, 8'h21, 1, 0, 0, 8'h22, 0);
    idle();
    cyc(1, 8'h23, 0, 0, 0, 0, 0);
    pulse_rst();
    cyc(1, 8'h24, 1, 0, 0, 8'h25, 0);
    idle();
    pulse_rst();
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + i), 1, 0, 0, 8'(8'h60 + i), 0);
    idle();
`ifdef SRAM_ARB_PERF_CNT_EN
    check("conflict_cnt", {32'd0, conflict_cnt}, 64'd5);
    check("p0_gnt_cnt", {32'd0, p0_gnt_cnt}, 64'd3);
    check("p1_gnt_cnt", {32'd0, p1_gnt_cnt}, 64'd2);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
